// File: rtl/half_to_int.sv
// rtl/half_to_int.sv - serial binary16 to int16 stream converter; HALF_TO_INT_ROUND_EN selects round-to-nearest-even
// One operand in flight; a bit-serial shifter aligns the mantissa before packing.
module half_to_int (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    output logic [15:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);

`ifdef HALF_TO_INT_ROUND_EN
    localparam bit ROUND_EN = 1'b1;
`else
    localparam bit ROUND_EN = 1'b0;
`endif

    typedef enum logic [2:0] {GET_A, UNPACK, SHIFT, ROUND, PACK, PUT_Z} state_t;

    state_t      state_q;
    logic [15:0] a_q;
    logic [15:0] v_q;
    logic [3:0]  cnt_q;
    logic        left_q;
    logic        guard_q;
    logic        round_q;
    logic        sticky_q;
    logic        special_q;
    logic [15:0] spec_val_q;
    logic        ack_q;
    logic        stb_q;
    logic [15:0] z_q;

    logic              sign;
    logic [4:0]        expo;
    logic [9:0]        frac;
    logic signed [6:0] e;
    logic signed [6:0] diff;
    logic [6:0]        n_abs;
    logic              uflow;
    logic              rnd_up;
    logic              sat;
    logic [15:0]       sat_val;

    assign sign    = a_q[15];
    assign expo    = a_q[14:10];
    assign frac    = a_q[9:0];
    assign e       = $signed({2'b00, expo}) - 7'sd15;
    assign diff    = e - 7'sd10;
    assign n_abs   = diff[6] ? 7'(-diff) : 7'(diff);
    // Rounding lets e=-1 reach the shifter so values in (0.5,1) can round up.
    assign uflow   = ROUND_EN ? (e < -7'sd1) : (e < 7'sd0);
    assign rnd_up  = guard_q & (round_q | sticky_q | v_q[0]);
    assign sat     = sign ? (v_q > 16'd32768) : (v_q > 16'd32767);
    assign sat_val = sign ? 16'h8000 : 16'h7FFF;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= GET_A;
            a_q        <= '0;
            v_q        <= '0;
            cnt_q      <= '0;
            left_q     <= 1'b0;
            guard_q    <= 1'b0;
            round_q    <= 1'b0;
            sticky_q   <= 1'b0;
            special_q  <= 1'b0;
            spec_val_q <= '0;
            ack_q      <= 1'b0;
            stb_q      <= 1'b0;
            z_q        <= '0;
        end else begin
            case (state_q)
                GET_A: begin
                    if (ack_q && input_a_stb) begin
                        a_q     <= input_a;
                        ack_q   <= 1'b0;
                        state_q <= UNPACK;
                    end else begin
                        ack_q <= 1'b1;
                    end
                end
                UNPACK: begin
                    v_q       <= {5'b0, 1'b1, frac};
                    guard_q   <= 1'b0;
                    round_q   <= 1'b0;
                    sticky_q  <= 1'b0;
                    cnt_q     <= n_abs[3:0];
                    left_q    <= !diff[6];
                    special_q <= 1'b1;
                    state_q   <= PACK;
                    if (expo == 5'd31) begin
                        spec_val_q <= (frac != 10'd0) ? 16'h8000 : sat_val;
                    end else if (expo == 5'd0 || uflow) begin
                        spec_val_q <= 16'h0000;
                    end else if (e >= 7'sd15) begin
                        // -32768 is exact; everything else saturates, which gives the same code by sign.
                        spec_val_q <= sat_val;
                    end else begin
                        special_q <= 1'b0;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= ROUND;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                        if (left_q) begin
                            v_q <= {v_q[14:0], 1'b0};
                        end else begin
                            v_q      <= {1'b0, v_q[15:1]};
                            guard_q  <= v_q[0];
                            round_q  <= guard_q;
                            sticky_q <= sticky_q | round_q;
                        end
                    end
                end
                ROUND: begin
                    if (ROUND_EN && rnd_up) begin
                        v_q <= v_q + 16'd1;
                    end
                    state_q <= PACK;
                end
                PACK: begin
                    if (special_q)
                        z_q <= spec_val_q;
                    else if (sat)
                        z_q <= sat_val;
                    else if (sign)
                        z_q <= 16'(-v_q);
                    else
                        z_q <= v_q;
                    stb_q   <= 1'b1;
                    state_q <= PUT_Z;
                end
                PUT_Z: begin
                    if (output_z_ack) begin
                        stb_q   <= 1'b0;
                        ack_q   <= 1'b1;
                        state_q <= GET_A;
                    end
                end
                default: state_q <= GET_A;
            endcase
        end
    end

    assign input_a_ack  = ack_q;
    assign output_z_stb = stb_q;
    assign output_z     = z_q;

endmodule
